// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - one-entry fetch buffer in front of a multi-cycle SRAM for the CPU fetch port
module inst_fetch_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rom_ce_i,
  input  logic [31:0]        rom_addr_i,
  output logic [31:0]        rom_data_o,
  output logic               stall_req_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  input  logic [31:0]        sram_data_i,
  output logic [31:0]        miss_cnt_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);

  logic [0:0]         state_q,     state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [29:0]        buf_tag_q,   buf_tag_d;
  logic [31:0]        buf_data_q,  buf_data_d;
  logic [29:0]        req_word_q,  req_word_d;
  logic [3:0]         cnt_q,       cnt_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               ce_n_q,      ce_n_d;
  logic               oe_n_q,      oe_n_d;
  logic [31:0]        miss_cnt_q,  miss_cnt_d;

  logic hit;
  logic unused_addr_lsbs;

  // Byte-lane bits do not select a different instruction word.
  assign unused_addr_lsbs = ^rom_addr_i[1:0];

  assign hit = rom_ce_i & buf_valid_q & (buf_tag_q == rom_addr_i[31:2]);

  // Fetch response: a hit answers immediately, but never while an SRAM read is still in flight.
  always_comb begin
    rom_data_o  = 32'h0;
    stall_req_o = 1'b0;
    if (rom_ce_i) begin
      if (hit && (state_q == ST_IDLE)) begin
        rom_data_o = buf_data_q;
      end else begin
        stall_req_o = 1'b1;
      end
    end
  end

  // Next state: start an SRAM read on a miss, count down wait states, then fill the buffer.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    req_word_d  = req_word_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        if (rom_ce_i && !hit) begin
          req_word_d  = rom_addr_i[31:2];
          sram_addr_d = rom_addr_i[SRAM_AW+1:2];
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          cnt_d       = CNT_INIT;
          miss_cnt_d  = miss_cnt_q + 32'd1;
          state_d     = ST_ACCESS;
        end
      end
      default: begin
        // The access always runs to completion using the latched word, whatever the CPU does meanwhile.
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d       = 4'd0;
          buf_data_d  = sram_data_i;
          buf_tag_d   = req_word_q;
          buf_valid_d = 1'b1;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // State registers; reset drops any access in flight and leaves the buffer invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 30'h0;
      buf_data_q  <= 32'h0;
      req_word_q  <= 30'h0;
      cnt_q       <= 4'd0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      miss_cnt_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      req_word_q  <= req_word_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign sram_addr_o = sram_addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule
